if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 jump_flag_i  input  1  redirect request from execute stage.
REQ-006 jump_addr_i  input  32  redirect target; word-aligned by the sender.
REQ-007 hold_flag_i  input  3  pipeline hold code; fetch holds when value >= 3'd1.
REQ-008 ibus_req_o  output  1  instruction bus request.
REQ-009 ibus_addr_o  output  32  instruction bus address.
REQ-010 ibus_ack_i  input  1  bus completion; ibus_data_i valid in that cycle only.
REQ-011 ibus_data_i  input  32  fetched instruction word.
REQ-012 inst_o  output  32  instruction to the IF/ID pipeline register.
REQ-013 inst_addr_o  output  32  address of inst_o.

Function
REQ-014 State machine SHALL have states IDLE (no request outstanding), WAIT (request outstanding, data wanted) and DROP (request outstanding, data to be discarded).
REQ-015 Internal registers: pc (32b), one-entry buffer buf_inst/buf_addr with buf_valid.
REQ-016 Bus rule: once ibus_req_o rises, ibus_req_o and ibus_addr_o SHALL stay constant until the cycle ibus_ack_i=1; ack arrives >=1 cycle after req rises; ack with req low SHALL be ignored.
REQ-017 ibus_addr_o SHALL always equal the address of the outstanding request; in IDLE it equals pc.
REQ-018 IDLE, no jump, hold inactive, buf_valid=0: next state WAIT, req asserted with addr=pc.
REQ-019 WAIT, ack, no jump, hold inactive: inst_o<=ibus_data_i, inst_addr_o<=request address, pc<=pc+4 (mod 2^32); a new request for pc+4 is issued in the same cycle (back-to-back, stay WAIT).
REQ-020 WAIT, ack, no jump, hold active: data and address SHALL go to the buffer (buf_valid<=1), pc<=pc+4, inst_o/inst_addr_o retained, next state IDLE.
REQ-021 WAIT, no ack, hold active: request SHALL stay asserted (REQ-016); inst_o/inst_addr_o retained.
REQ-022 Any cycle where hold is inactive and no instruction is presented: inst_o<=NOP_INST, inst_addr_o<=32'h0.
REQ-023 IDLE, hold inactive, buf_valid=1: inst_o/inst_addr_o<=buffer, buf_valid<=0; fetch of pc starts the following cycle.
REQ-024 While hold active, inst_o/inst_addr_o SHALL retain their value except on jump (REQ-026).
REQ-025 Jump with no outstanding request (IDLE): pc<=jump_addr_i, buf_valid<=0, stay IDLE; no request issued that cycle.
REQ-026 Jump in any state, regardless of hold: inst_o<=NOP_INST, inst_addr_o<=32'h0, buf_valid<=0, pc<=jump_addr_i.
REQ-027 Jump in WAIT with ack same cycle: returned data dropped, next state IDLE.
REQ-028 Jump in WAIT without ack: next state DROP; request held with old address.
REQ-029 DROP, ack: data discarded, next state IDLE; a further jump in DROP only updates pc.
REQ-030 Fetched data SHALL never reach inst_o or the buffer in DROP or in a jump cycle.
REQ-031 Priority per cycle: rst > jump > ack handling > hold > new request.

Reset
REQ-032 On rst=1 at a rising edge: state<=IDLE, pc<=RESET_ADDR, buf_valid<=0, inst_o<=NOP_INST, inst_addr_o<=32'h0; ibus_req_o=0 in the following cycle.
REQ-033 rst mid-request SHALL abandon the outstanding request without waiting for ack; a late ack after reset is ignored (REQ-016).
REQ-034 First request after reset deassertion SHALL use address RESET_ADDR.

Verification
REQ-035 Reset release, memory acks every cycle one cycle after req, data=addr^32'hA5A5_0000 -> inst_addr_o sequence 0,4,8,... one per cycle after initial latency; inst_o matches.
REQ-036 Ack at 0x8 while hold_flag_i=3'd2 for 3 cycles -> inst_o retained, buffer holds 0x8, no new req; on release inst_addr_o=0x8, then req for 0xC.
REQ-037 Jump to 0x100 while request 0x10 outstanding, ack 2 cycles later -> ibus_addr_o stays 0x10 until ack, data dropped, inst_o=0x13 bubbles, next req 0x100.
REQ-038 Jump and ack same cycle -> data dropped, inst_o=32'h13, next req at jump_addr_i.
REQ-039 Assert rst while request outstanding -> inst_o=32'h13, inst_addr_o=0, next req 0x0; stray ack ignored.
REQ-040 pc=32'hFFFF_FFFC fetched -> next req address 32'h0000_0000 (wrap).

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch -- instruction fetch stage.
// Keeps the program counter, issues one instruction-bus request at a time and
// hands fetched words to the IF/ID register. A one-entry buffer catches a word
// that returns while the pipeline is held. A redirect that arrives while a
// request is still outstanding makes the returning word be discarded.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous reset, active high
//   jump_flag_i  in   1   redirect request from execute
//   jump_addr_i  in  32   redirect target (word aligned)
//   hold_flag_i  in   3   pipeline hold code, fetch holds when non-zero
//   ibus_req_o   out  1   instruction bus request
//   ibus_addr_o  out 32   instruction bus address
//   ibus_ack_i   in   1   bus completion, data valid this cycle only
//   ibus_data_i  in  32   fetched instruction word
//   inst_o       out 32   instruction to IF/ID
//   inst_addr_o  out 32   address of inst_o
//
// state  | meaning
// S_IDLE | no request outstanding; bus address shows pc
// S_WAIT | request outstanding, returned word is wanted
// S_DROP | request outstanding, returned word is discarded (redirected)

module if_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [2:0]  hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_req;
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_addr;
  logic        r_buf_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;

  logic        w_hold;
  logic        w_ack;
  logic [31:0] w_pc_inc;

  assign w_hold   = (hold_flag_i >= 3'd1);
  // An ack only means something while our request is on the bus.
  assign w_ack    = r_req & ibus_ack_i;
  assign w_pc_inc = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_ADDR;
      r_req       <= 1'b0;
      r_buf_valid <= 1'b0;
      r_inst      <= NOP_INST;
      r_inst_addr <= 32'h0;
    end else if (jump_flag_i) begin
      // Redirect wins over everything else and always bubbles the output.
      r_pc        <= jump_addr_i;
      r_buf_valid <= 1'b0;
      r_inst      <= NOP_INST;
      r_inst_addr <= 32'h0;
      if (r_state != S_IDLE) begin
        if (w_ack) begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end else begin
          // Bus protocol forbids withdrawing the request; wait it out.
          r_state <= S_DROP;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_hold) begin
            if (r_buf_valid) begin
              r_inst      <= r_buf_inst;
              r_inst_addr <= r_buf_addr;
              r_buf_valid <= 1'b0;
            end else begin
              r_inst      <= NOP_INST;
              r_inst_addr <= 32'h0;
              r_req       <= 1'b1;
              r_req_addr  <= r_pc;
              r_state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_ack) begin
            r_pc <= w_pc_inc;
            if (w_hold) begin
              r_buf_inst  <= ibus_data_i;
              r_buf_addr  <= r_req_addr;
              r_buf_valid <= 1'b1;
              r_req       <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              // Back-to-back: next sequential request goes out immediately.
              r_inst      <= ibus_data_i;
              r_inst_addr <= r_req_addr;
              r_req_addr  <= w_pc_inc;
            end
          end else if (!w_hold) begin
            r_inst      <= NOP_INST;
            r_inst_addr <= 32'h0;
          end
        end
        S_DROP: begin
          if (w_ack) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
          if (!w_hold) begin
            r_inst      <= NOP_INST;
            r_inst_addr <= 32'h0;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ibus_req_o  = r_req;
  assign ibus_addr_o = r_req ? r_req_addr : r_pc;
  assign inst_o      = r_inst;
  assign inst_addr_o = r_inst_addr;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch -- randomized bench for if_fetch.
// A bus responder obeys the request/ack protocol (ack no earlier than one cycle
// after req rises, stray acks while req is low). A transaction-level reference
// model tracks pc, the outstanding request (wanted or discarded) and a queue of
// parked words, and predicts the DUT outputs each cycle.

module tb_if_fetch;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;
  localparam int          NCYC  = 4000;
  localparam int          PHASE = 250;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_data_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  if_fetch #(.RESET_ADDR(RST_A), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .hold_flag_i (hold_flag_i),
    .ibus_req_o  (ibus_req_o),
    .ibus_addr_o (ibus_addr_o),
    .ibus_ack_i  (ibus_ack_i),
    .ibus_data_i (ibus_data_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %08h expected %08h", tag, $time, got, exp);
    end
  endtask

  // Reference model: what the fetch stage should be showing.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_iaddr;
  logic [31:0] m_req_addr;
  bit          m_req_live;
  bit          m_discard;
  logic [63:0] m_buf[$];

  task automatic model_reset();
    m_pc       = RST_A;
    m_inst     = NOP;
    m_iaddr    = 32'h0;
    m_req_addr = 32'h0;
    m_req_live = 1'b0;
    m_discard  = 1'b0;
    m_buf.delete();
  endtask

  task automatic model_step(input bit r, input bit j, input logic [31:0] ja,
                            input logic [2:0] h, input bit a, input logic [31:0] d);
    bit          hold_on;
    bit          got;
    logic [63:0] ent;
    hold_on = (h != 3'd0);
    got     = a && m_req_live;
    if (r) begin
      model_reset();
    end else if (j) begin
      m_inst  = NOP;
      m_iaddr = 32'h0;
      m_buf.delete();
      m_pc    = ja;
      if (got) begin
        m_req_live = 1'b0;
        m_discard  = 1'b0;
      end else if (m_req_live) begin
        m_discard = 1'b1;
      end
    end else if (got && m_discard) begin
      m_req_live = 1'b0;
      m_discard  = 1'b0;
      if (!hold_on) begin
        m_inst  = NOP;
        m_iaddr = 32'h0;
      end
    end else if (got) begin
      if (hold_on) begin
        m_buf.push_back({m_req_addr, d});
        m_req_live = 1'b0;
      end else begin
        m_inst  = d;
        m_iaddr = m_req_addr;
      end
      m_pc = m_pc + 32'd4;
      if (!hold_on) m_req_addr = m_pc;
    end else if (!hold_on) begin
      if (m_req_live) begin
        m_inst  = NOP;
        m_iaddr = 32'h0;
      end else if (m_buf.size() > 0) begin
        ent     = m_buf.pop_front();
        m_inst  = ent[31:0];
        m_iaddr = ent[63:32];
      end else begin
        m_inst     = NOP;
        m_iaddr    = 32'h0;
        m_req_live = 1'b1;
        m_req_addr = m_pc;
      end
    end
  endtask

  initial begin
    int          mode;
    int          ack_pct;
    int          hold_tgl;
    int          jump_pct;
    int          rst_pct;
    bit          hold_on;
    bit          prev_req;
    int          req_age;
    logic [31:0] tgt;

    rst         = 1'b1;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'h0;
    hold_flag_i = 3'd0;
    ibus_ack_i  = 1'b0;
    ibus_data_i = 32'h0;
    hold_on     = 1'b0;
    prev_req    = 1'b0;
    req_age     = 0;
    model_reset();
    repeat (3) @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_val("ibus_req",  {31'd0, ibus_req_o}, {31'd0, m_req_live});
      check_val("ibus_addr", ibus_addr_o, m_req_live ? m_req_addr : m_pc);
      check_val("inst",      inst_o, m_inst);
      check_val("inst_addr", inst_addr_o, m_iaddr);

      mode = (cyc / PHASE) % 4;
      case (mode)
        0:       begin ack_pct = 100; hold_tgl = 0;  jump_pct = 1; rst_pct = 0; end
        1:       begin ack_pct = 50;  hold_tgl = 20; jump_pct = 5; rst_pct = 1; end
        2:       begin ack_pct = 30;  hold_tgl = 35; jump_pct = 5; rst_pct = 1; end
        default: begin ack_pct = 100; hold_tgl = 15; jump_pct = 8; rst_pct = 1; end
      endcase
      if (mode == 0) hold_on = 1'b0;
      else if ($urandom_range(99) < hold_tgl) hold_on = !hold_on;

      rst         = (cyc > 0) && ($urandom_range(199) < rst_pct);
      hold_flag_i = hold_on ? 3'($urandom_range(7, 1)) : 3'd0;

      // A redirect near the top of memory at each phase start forces a pc wrap.
      if (cyc % PHASE == 0) begin
        jump_flag_i = 1'b1;
        jump_addr_i = 32'hFFFF_FFF0;
      end else if ($urandom_range(99) < jump_pct) begin
        jump_flag_i = 1'b1;
        case ($urandom_range(3))
          0:       tgt = 32'h0000_0100;
          1:       tgt = 32'hFFFF_FFF8;
          2:       tgt = 32'hFFFF_FFFC;
          default: tgt = $urandom() & 32'hFFFF_FFFC;
        endcase
        jump_addr_i = tgt;
      end else begin
        jump_flag_i = 1'b0;
        jump_addr_i = $urandom() & 32'hFFFF_FFFC;
      end

      // Bus responder: ack at least one cycle after req rose.
      if (ibus_req_o) req_age = prev_req ? req_age + 1 : 0;
      prev_req = ibus_req_o;
      if (ibus_req_o && req_age >= 1 && $urandom_range(99) < ack_pct) begin
        ibus_ack_i  = 1'b1;
        ibus_data_i = ibus_addr_o ^ XMASK;
      end else if (!ibus_req_o && $urandom_range(7) == 0) begin
        ibus_ack_i  = 1'b1;
        ibus_data_i = $urandom();
      end else begin
        ibus_ack_i  = 1'b0;
        ibus_data_i = $urandom();
      end

      model_step(rst, jump_flag_i, jump_addr_i, hold_flag_i, ibus_ack_i, ibus_data_i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
